// File: rtl/sext_compressor_if.sv
// Word-in / beat-out bundle for sext_compressor; master is the core/link side,
// slave is the compressor itself.
interface sext_compressor_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_compact;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_compact
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_compact
    );
endinterface

// File: rtl/sext_compressor.sv
// Splits 32-bit words into 16-bit beats, one beat when the high half is a sign extension.
// First beat one cycle after acceptance; beats hold under out_ready low, in_ready only in IDLE.
module sext_compressor #(
    parameter bit COMPACT_EN = 1'b1,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    sext_compressor_if.slave   bus,
    output logic [COUNT_W-1:0] word_cnt,
    output logic [COUNT_W-1:0] compact_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        hi_q, hi_d;
    logic [15:0]        out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               out_compact_q, out_compact_d;
    logic [COUNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [COUNT_W-1:0] compact_cnt_q, compact_cnt_d;

    logic accept;
    logic fits;
    logic beat_done;

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign fits      = COMPACT_EN && (bus.in_data[31:16] == {16{bus.in_data[15]}});
    assign beat_done = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = SEND_LO;
            SEND_LO: if (beat_done) state_d = out_last_q ? IDLE : SEND_HI;
            SEND_HI: if (beat_done) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        hi_d          = hi_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        out_compact_d = out_compact_q;
        word_cnt_d    = word_cnt_q;
        compact_cnt_d = compact_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    hi_d          = bus.in_data[31:16];
                    out_data_d    = bus.in_data[15:0];
                    out_valid_d   = 1'b1;
                    out_compact_d = fits;
                    out_last_d    = fits;
                    // Counters stick at all-ones rather than wrapping.
                    if (word_cnt_q != {COUNT_W{1'b1}}) begin
                        word_cnt_d = word_cnt_q + COUNT_W'(1);
                    end
                    if (fits && (compact_cnt_q != {COUNT_W{1'b1}})) begin
                        compact_cnt_d = compact_cnt_q + COUNT_W'(1);
                    end
                end
            end
            SEND_LO: begin
                if (beat_done) begin
                    if (out_last_q) begin
                        out_valid_d   = 1'b0;
                        out_last_d    = 1'b0;
                        out_compact_d = 1'b0;
                    end else begin
                        out_data_d = hi_q;
                        out_last_d = 1'b1;
                    end
                end
            end
            SEND_HI: begin
                if (beat_done) begin
                    out_valid_d   = 1'b0;
                    out_last_d    = 1'b0;
                    out_compact_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q          <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_compact_q <= 1'b0;
            word_cnt_q    <= '0;
            compact_cnt_q <= '0;
        end else begin
            hi_q          <= hi_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            out_compact_q <= out_compact_d;
            word_cnt_q    <= word_cnt_d;
            compact_cnt_q <= compact_cnt_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_compact = out_compact_q;
    assign word_cnt        = word_cnt_q;
    assign compact_cnt     = compact_cnt_q;

endmodule

// File: tb/tb_sext_compressor.sv
// Bench for sext_compressor: three instances (default, no compaction, 2-bit counters)
// checked against a beat-queue reference model plus boundary-word tables.
module tb_sext_compressor;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    sext_compressor_if if0 ();
    sext_compressor_if if1 ();
    sext_compressor_if if2 ();

    logic [15:0] wc0, cc0, wc1, cc1;
    logic [1:0]  wc2, cc2;

    sext_compressor #(.COMPACT_EN(1'b1), .COUNT_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave), .word_cnt(wc0), .compact_cnt(cc0));
    sext_compressor #(.COMPACT_EN(1'b0), .COUNT_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave), .word_cnt(wc1), .compact_cnt(cc1));
    sext_compressor #(.COMPACT_EN(1'b1), .COUNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave), .word_cnt(wc2), .compact_cnt(cc2));

    logic        vld  [3];
    logic [31:0] din  [3];
    logic        ordy [3];
    logic        ir [3], ov [3], ol [3], oc [3];
    logic [15:0] od [3], wc [3], cc [3];

    assign if0.in_valid = vld[0];  assign if0.in_data = din[0];  assign if0.out_ready = ordy[0];
    assign if1.in_valid = vld[1];  assign if1.in_data = din[1];  assign if1.out_ready = ordy[1];
    assign if2.in_valid = vld[2];  assign if2.in_data = din[2];  assign if2.out_ready = ordy[2];

    assign ir[0] = if0.in_ready;  assign ov[0] = if0.out_valid;  assign od[0] = if0.out_data;
    assign ol[0] = if0.out_last;  assign oc[0] = if0.out_compact;
    assign ir[1] = if1.in_ready;  assign ov[1] = if1.out_valid;  assign od[1] = if1.out_data;
    assign ol[1] = if1.out_last;  assign oc[1] = if1.out_compact;
    assign ir[2] = if2.in_ready;  assign ov[2] = if2.out_valid;  assign od[2] = if2.out_data;
    assign ol[2] = if2.out_last;  assign oc[2] = if2.out_compact;
    assign wc[0] = wc0;  assign cc[0] = cc0;
    assign wc[1] = wc1;  assign cc[1] = cc1;
    assign wc[2] = {14'b0, wc2};  assign cc[2] = {14'b0, cc2};

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        compact;
    } beat_t;

    typedef struct {
        logic [31:0] w;
        bit          c;
    } vec_t;

    beat_t exp_q[$];
    int    wm [3];
    int    cm [3];
    int    nerr = 0;
    int    nchk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A word is compact when, read as signed, it fits in 16 bits.
    function automatic bit model_compact(input logic [31:0] w, input bit en);
        int s;
        s = $signed(w);
        return en && (s >= -32768) && (s <= 32767);
    endfunction

    function automatic int cap(input int k);
        return (k == 2) ? 3 : 65535;
    endfunction

    task automatic observe(input int k);
        bit    idle;
        bit    c;
        beat_t b;
        idle = (exp_q.size() == 0);
        chk("in_ready", 32'(ir[k]), 32'(idle));
        chk("out_valid", 32'(ov[k]), 32'(!idle));
        chk("word_cnt", 32'(wc[k]), 32'(wm[k]));
        chk("compact_cnt", 32'(cc[k]), 32'(cm[k]));
        if (!idle && ov[k]) begin
            chk("beat_data", 32'(od[k]), 32'(exp_q[0].data));
            chk("beat_last", 32'(ol[k]), 32'(exp_q[0].last));
            chk("beat_compact", 32'(oc[k]), 32'(exp_q[0].compact));
            if (ordy[k]) void'(exp_q.pop_front());
        end
        if (vld[k] && idle) begin
            c = model_compact(din[k], k != 1);
            b.data = din[k][15:0];
            b.last = c;
            b.compact = c;
            exp_q.push_back(b);
            if (!c) begin
                b.data = din[k][31:16];
                b.last = 1'b1;
                b.compact = 1'b0;
                exp_q.push_back(b);
            end
            if (wm[k] < cap(k)) wm[k]++;
            if (c && cm[k] < cap(k)) cm[k]++;
        end
    endtask

    task automatic tick(input int k);
        @(negedge clk);
        observe(k);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int k);
        vld[k]  = 1'b0;
        ordy[k] = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick(k);
        if (exp_q.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send_one(input int k, input logic [31:0] w);
        vld[k] = 1'b1;
        din[k] = w;
        tick(k);
        vld[k] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tab [8];
        logic [15:0] r16;

        tab[0] = '{32'h0000_8000, 1'b0};
        tab[1] = '{32'hFFFF_7FFF, 1'b0};
        tab[2] = '{32'hFFFF_FFFF, 1'b1};
        tab[3] = '{32'h0000_0000, 1'b1};
        tab[4] = '{32'hFFFF_8000, 1'b1};
        tab[5] = '{32'h0000_7FFF, 1'b1};
        tab[6] = '{32'h1234_5678, 1'b0};
        tab[7] = '{32'h0001_0000, 1'b0};

        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0; din[k] = '0; ordy[k] = 1'b1; wm[k] = 0; cm[k] = 0;
        end
        rst_n = 1'b0;
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", 32'(ir[k]), 32'd1);
            chk("rst_out_valid", 32'(ov[k]), 32'd0);
            chk("rst_out_data", 32'(od[k]), 32'd0);
            chk("rst_out_last", 32'(ol[k]), 32'd0);
            chk("rst_out_compact", 32'(oc[k]), 32'd0);
            chk("rst_word_cnt", 32'(wc[k]), 32'd0);
            chk("rst_compact_cnt", 32'(cc[k]), 32'd0);
        end

        // Boundary words, first beat checked against hand-written expectations.
        for (int i = 0; i < 8; i++) begin
            send_one(0, tab[i].w);
            chk("tab_lo", 32'(od[0]), 32'(tab[i].w[15:0]));
            chk("tab_compact", 32'(oc[0]), 32'(tab[i].c));
            chk("tab_last", 32'(ol[0]), 32'(tab[i].c));
            chk("tab_busy", 32'(ir[0]), 32'd0);
            drain(0);
        end
        chk("tab_words", 32'(wc[0]), 32'd8);
        chk("tab_compacts", 32'(cc[0]), 32'd4);

        // Backpressure three cycles on each beat of a full word.
        ordy[0] = 1'b0;
        send_one(0, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick(0);
            chk("bp_lo_data", 32'(od[0]), 32'h0000_BEEF);
            chk("bp_lo_valid", 32'(ov[0]), 32'd1);
            chk("bp_lo_ready", 32'(ir[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        tick(0);
        chk("bp_hi_data", 32'(od[0]), 32'h0000_DEAD);
        chk("bp_hi_last", 32'(ol[0]), 32'd1);
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(0);
            chk("bp_hi_hold", 32'(od[0]), 32'h0000_DEAD);
            chk("bp_hi_valid", 32'(ov[0]), 32'd1);
            chk("bp_hi_ready", 32'(ir[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        tick(0);
        chk("bp_done_valid", 32'(ov[0]), 32'd0);
        chk("bp_done_ready", 32'(ir[0]), 32'd1);

        // Reset while the high beat is pending.
        send_one(0, 32'hABCD_1234);
        tick(0);
        chk("rsthi_state", 32'(od[0]), 32'h0000_ABCD);
        #2 rst_n = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin wm[k] = 0; cm[k] = 0; end
        #1;
        chk("rsthi_valid", 32'(ov[0]), 32'd0);
        chk("rsthi_ready", 32'(ir[0]), 32'd1);
        chk("rsthi_words", 32'(wc[0]), 32'd0);
        chk("rsthi_compacts", 32'(cc[0]), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) tick(0);
        chk("rsthi_no_trailing", 32'(ov[0]), 32'd0);

        // Compaction disabled: a small word still goes as two beats.
        send_one(1, 32'h0000_0005);
        chk("nc_lo_data", 32'(od[1]), 32'h0000_0005);
        chk("nc_lo_compact", 32'(oc[1]), 32'd0);
        chk("nc_lo_last", 32'(ol[1]), 32'd0);
        tick(1);
        chk("nc_hi_data", 32'(od[1]), 32'h0000_0000);
        chk("nc_hi_last", 32'(ol[1]), 32'd1);
        drain(1);
        chk("nc_compacts", 32'(cc[1]), 32'd0);
        chk("nc_words", 32'(wc[1]), 32'd1);

        // Two-bit counters saturate at 3.
        for (int i = 0; i < 5; i++) begin
            send_one(2, 32'h0000_0001);
            drain(2);
        end
        chk("sat_words", 32'(wc[2]), 32'd3);
        chk("sat_compacts", 32'(cc[2]), 32'd3);

        // Random traffic on every instance against the beat-queue model.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 600; n++) begin
                vld[k] = 1'($urandom_range(0, 1));
                r16 = 16'($urandom);
                if ($urandom_range(0, 1) == 1) din[k] = {{16{r16[15]}}, r16};
                else                           din[k] = $urandom;
                ordy[k] = ($urandom_range(0, 3) != 0);
                tick(k);
            end
            drain(k);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
